// File: rtl/vx_hpdcache_mem_rw_adapter_if.sv
// Bundle of cache-side read/write channels and memory-side request/response
// channels for the HPDcache memory read/write adapter.
interface vx_hpdcache_mem_rw_adapter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512,
  parameter int TAG_WIDTH  = 8
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;
  logic [TAG_WIDTH-1:0]  rd_req_id;
  logic                  rd_rsp_valid;
  logic                  rd_rsp_ready;
  logic [TAG_WIDTH-1:0]  rd_rsp_id;
  logic [DATA_WIDTH-1:0] rd_rsp_data;

  logic                  wr_req_valid;
  logic                  wr_req_ready;
  logic [ADDR_WIDTH-1:0] wr_req_addr;
  logic [TAG_WIDTH-1:0]  wr_req_id;
  logic                  wr_data_valid;
  logic                  wr_data_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_data_be;
  logic                  wr_rsp_valid;
  logic                  wr_rsp_ready;
  logic [TAG_WIDTH-1:0]  wr_rsp_id;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_rw;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [TAG_WIDTH-1:0]  mem_req_tag;
  logic [DATA_WIDTH-1:0] mem_req_data;
  logic [BE_WIDTH-1:0]   mem_req_byteen;
  logic                  mem_rsp_valid;
  logic                  mem_rsp_ready;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic [TAG_WIDTH-1:0]  mem_rsp_tag;

  // Adapter side
  modport slave (
    input  rd_req_valid, rd_req_addr, rd_req_id, rd_rsp_ready,
    output rd_req_ready, rd_rsp_valid, rd_rsp_id, rd_rsp_data,
    input  wr_req_valid, wr_req_addr, wr_req_id,
    input  wr_data_valid, wr_data, wr_data_be, wr_rsp_ready,
    output wr_req_ready, wr_data_ready, wr_rsp_valid, wr_rsp_id,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    output mem_req_data, mem_req_byteen, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );

  // Environment side (cache + memory)
  modport master (
    output rd_req_valid, rd_req_addr, rd_req_id, rd_rsp_ready,
    input  rd_req_ready, rd_rsp_valid, rd_rsp_id, rd_rsp_data,
    output wr_req_valid, wr_req_addr, wr_req_id,
    output wr_data_valid, wr_data, wr_data_be, wr_rsp_ready,
    input  wr_req_ready, wr_data_ready, wr_rsp_valid, wr_rsp_id,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    input  mem_req_data, mem_req_byteen, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_tag
  );
endinterface

// File: rtl/vx_hpdcache_mem_rw_adapter.sv
// Merges HPDcache read requests and split header/data writes onto one memory
// request bus; writes are posted and acknowledged locally through an id FIFO.
module vx_hpdcache_mem_rw_adapter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 512,
  parameter int TAG_WIDTH    = 8,
  parameter int WR_RSP_DEPTH = 4,
  parameter int ARB_RR       = 1
) (
  input logic clk,
  input logic reset,
  vx_hpdcache_mem_rw_adapter_if.slave bus
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int PTR_W = (WR_RSP_DEPTH > 1) ? $clog2(WR_RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(WR_RSP_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(WR_RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WR_RSP_DEPTH - 1);

  logic                  hdr_v_q, hdr_v_d;
  logic [ADDR_WIDTH-1:0] hdr_addr_q, hdr_addr_d;
  logic [TAG_WIDTH-1:0]  hdr_id_q, hdr_id_d;
  logic                  dat_v_q, dat_v_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic                  lock_q, lock_d;
  logic                  lock_wr_q, lock_wr_d;
  logic                  last_wr_q, last_wr_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0]  ack_mem_q [WR_RSP_DEPTH];

  logic rd_elig, wr_elig, grant_wr, grant_rd, mem_valid, mem_hs, ack_push, ack_pop;

  // Arbitration: a stalled request keeps its grant until it handshakes
  always_comb begin
    rd_elig  = bus.rd_req_valid;
    wr_elig  = hdr_v_q & dat_v_q & (cnt_q < DEPTH_C);
    grant_wr = 1'b0;
    if (lock_q) begin
      grant_wr = lock_wr_q;
    end else if (rd_elig && wr_elig) begin
      grant_wr = (ARB_RR != 0) ? ~last_wr_q : 1'b0;
    end else begin
      grant_wr = wr_elig;
    end
    grant_rd  = rd_elig & ~grant_wr;
    mem_valid = grant_wr | grant_rd;
    mem_hs    = mem_valid & bus.mem_req_ready;
    ack_push  = mem_hs & grant_wr;
    ack_pop   = (cnt_q != '0) & bus.wr_rsp_ready;
  end

  always_comb begin
    bus.mem_req_valid  = mem_valid;
    bus.mem_req_rw     = grant_wr;
    bus.mem_req_addr   = grant_wr ? hdr_addr_q : bus.rd_req_addr;
    bus.mem_req_tag    = grant_wr ? hdr_id_q : bus.rd_req_id;
    bus.mem_req_data   = grant_wr ? dat_q : '0;
    bus.mem_req_byteen = grant_wr ? be_q : '1;
    bus.rd_req_ready   = grant_rd & bus.mem_req_ready;
    bus.wr_req_ready   = ~hdr_v_q;
    bus.wr_data_ready  = ~dat_v_q;
    bus.wr_rsp_valid   = (cnt_q != '0);
    bus.wr_rsp_id      = ack_mem_q[rptr_q];
    bus.rd_rsp_valid   = bus.mem_rsp_valid;
    bus.rd_rsp_id      = bus.mem_rsp_tag;
    bus.rd_rsp_data    = bus.mem_rsp_data;
    bus.mem_rsp_ready  = bus.rd_rsp_ready;
  end

  always_comb begin
    hdr_v_d    = hdr_v_q;
    hdr_addr_d = hdr_addr_q;
    hdr_id_d   = hdr_id_q;
    dat_v_d    = dat_v_q;
    dat_d      = dat_q;
    be_d       = be_q;
    if (ack_push) begin
      hdr_v_d = 1'b0;
      dat_v_d = 1'b0;
    end
    if (!hdr_v_q && bus.wr_req_valid) begin
      hdr_v_d    = 1'b1;
      hdr_addr_d = bus.wr_req_addr;
      hdr_id_d   = bus.wr_req_id;
    end
    if (!dat_v_q && bus.wr_data_valid) begin
      dat_v_d = 1'b1;
      dat_d   = bus.wr_data;
      be_d    = bus.wr_data_be;
    end
    lock_d    = mem_valid & ~bus.mem_req_ready;
    lock_wr_d = grant_wr;
    last_wr_d = mem_hs ? grant_wr : last_wr_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    cnt_d     = cnt_q;
    if (ack_push) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
    if (ack_pop)  rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
    case ({ack_push, ack_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; last_wr resets high so the first conflict favours reads
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_v_q   <= 1'b0;
      dat_v_q   <= 1'b0;
      lock_q    <= 1'b0;
      lock_wr_q <= 1'b0;
      last_wr_q <= 1'b1;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      hdr_v_q   <= hdr_v_d;
      dat_v_q   <= dat_v_d;
      lock_q    <= lock_d;
      lock_wr_q <= lock_wr_d;
      last_wr_q <= last_wr_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    hdr_addr_q <= hdr_addr_d;
    hdr_id_q   <= hdr_id_d;
    dat_q      <= dat_d;
    be_q       <= be_d;
    if (ack_push) ack_mem_q[wptr_q] <= hdr_id_q;
  end
endmodule
